ram_responder: RTL and testbench
================================

RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 Parameter ADDR_W, default 8, address width; the array holds 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 8, data word width.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset, named clk and reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-high; forces the reset state immediately.
REQ-006 Address  input  ADDR_W  word address driven by the CPU MAR.
REQ-007 Data  inout  DATA_W  shared CPU data bus; driven only in DRIVE state, otherwise high-Z.
REQ-008 mem_read  input  1  CPU read request, level, held until mem_ready is seen.
REQ-009 mem_write  input  1  CPU write request, level, held until mem_ready is seen.
REQ-010 mem_ready  output  1  access acknowledge.
REQ-011 prog_start  input  1  one-cycle pulse that starts a bulk program load.
REQ-012 prog_valid  input  1  prog_data carries a valid byte this cycle.
REQ-013 prog_data  input  DATA_W  program byte.
REQ-014 prog_busy  output  1  high while a program load is in progress.
REQ-015 prog_done  output  1  one-cycle pulse after the last program byte is written.

Function
REQ-016 The FSM SHALL have states IDLE, RD, DRIVE, WACK and PROG.
REQ-017 IDLE, mem_write=1: write Data into mem[Address] at that edge -> WACK.
REQ-018 IDLE, mem_read=1, mem_write=0: capture Address -> RD.
REQ-019 Write priority: when both requests are high in IDLE, the block SHALL perform the write only.
REQ-020 RD: load rd_buf from mem[captured address] -> DRIVE unconditionally.
REQ-021 DRIVE: Data=rd_buf, mem_ready=1; mem_read=0 -> IDLE (bus high-Z next cycle); otherwise stay.
REQ-022 Read latency: mem_ready SHALL rise on the 2nd rising edge after the edge that samples mem_read in IDLE.
REQ-023 WACK: mem_ready=1; mem_write=0 -> IDLE; otherwise stay, with no further writes.
REQ-024 IDLE, prog_start=1, no CPU request: ptr=0, prog_busy=1 -> PROG.
REQ-025 CPU requests SHALL take priority over prog_start in IDLE; prog_start is ignored in every other state.
REQ-026 PROG: each prog_valid cycle writes prog_data to mem[ptr] and increments ptr.
REQ-027 PROG: prog_valid=0 cycles SHALL hold ptr and leave memory unchanged.
REQ-028 PROG SHALL ignore mem_read and mem_write, with mem_ready=0 and Data high-Z.
REQ-029 PROG exit: the write to ptr=2**ADDR_W-1 SHALL pulse prog_done for one cycle, drop prog_busy, wrap ptr to 0 and return to IDLE.
REQ-030 mem_ready SHALL be low in IDLE, RD and PROG.
REQ-031 Data SHALL never be driven outside DRIVE state.

Reset
REQ-032 On reset the block SHALL set state=IDLE, mem_ready=0, prog_busy=0, prog_done=0, ptr=0 and rd_buf=0, with Data high-Z.
REQ-033 Memory contents SHALL NOT be cleared by reset.
REQ-034 A reset during PROG SHALL abort the load with no prog_done; bytes already written SHALL remain.
REQ-035 A reset during DRIVE SHALL release Data in the same cycle.

Verification
REQ-036 Write/read: write 0x5A to address 0x10; read 0x10 -> mem_ready rises 2 edges after mem_read is sampled, and Data=0x5A.
REQ-037 Held requests: hold mem_write for 4 cycles with Data changing -> exactly one write (the first value) and mem_ready high until release.
REQ-038 Simultaneous requests: mem_read=mem_write=1 at address 0x20 with Data=0x33 -> mem[0x20]=0x33, WACK state, Data never driven.
REQ-039 Program load: prog_start, then 256 bytes i^0xFF with random prog_valid gaps -> exactly one prog_done after byte 255, and reads return i^0xFF.
REQ-040 Reset mid-PROG: reset after 10 bytes -> prog_busy=0 immediately, no prog_done, mem[0..9] retained, and ptr=0 on a fresh prog_start.
REQ-041 Bus release: drop mem_read in DRIVE -> Data is Z on the next cycle; a bench assertion checks Data is never driven outside DRIVE.

Source files
------------

// File: rtl/ram_responder.sv
// ram_responder: word-addressed RAM that answers a simple CPU read/write
// handshake on a shared bidirectional data bus. It also accepts a bulk
// program load that fills the whole array in address order.
//
// Ports
//   clk         rising-edge clock for all state
//   reset       asynchronous, active-high reset
//   Address     CPU word address (ADDR_W)
//   Data        shared CPU data bus (DATA_W), driven only while in DRIVE
//   mem_read    CPU read request, level, held until mem_ready
//   mem_write   CPU write request, level, held until mem_ready
//   mem_ready   access acknowledge
//   prog_start  one-cycle pulse that starts a program load
//   prog_valid  prog_data is valid this cycle
//   prog_data   program byte (DATA_W)
//   prog_busy   high while a program load is in progress
//   prog_done   one-cycle pulse after the last program byte is written
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a CPU request or prog_start
// RD    | fetching the captured address into rd_buf
// DRIVE | rd_buf on Data, acknowledging until mem_read drops
// WACK  | write already done, acknowledging until mem_write drops
// PROG  | bulk load, one byte per prog_valid cycle at mem[ptr]

module ram_responder #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] Address,
   inout  wire  [DATA_W-1:0] Data,
   input  logic              mem_read,
   input  logic              mem_write,
   output logic              mem_ready,
   input  logic              prog_start,
   input  logic              prog_valid,
   input  logic [DATA_W-1:0] prog_data,
   output logic              prog_busy,
   output logic              prog_done
);

   localparam int MEM_DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] PTR_LAST = '1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RD    = 3'd1;
   localparam logic [2:0] S_DRIVE = 3'd2;
   localparam logic [2:0] S_WACK  = 3'd3;
   localparam logic [2:0] S_PROG  = 3'd4;

   logic [2:0]        state;
   logic [2:0]        state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] ptr;
   logic [DATA_W-1:0] rd_buf;
   logic [DATA_W-1:0] mem [0:MEM_DEPTH-1];

   logic              cpu_we;
   logic              prog_we;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (mem_write)
               state_nxt = S_WACK;
            else if (mem_read)
               state_nxt = S_RD;
            else if (prog_start)
               state_nxt = S_PROG;
         end
         S_RD:    state_nxt = S_DRIVE;
         S_DRIVE: if (!mem_read)  state_nxt = S_IDLE;
         S_WACK:  if (!mem_write) state_nxt = S_IDLE;
         S_PROG:  if (prog_valid && (ptr == PTR_LAST)) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // One shared write port: the CPU write and the program loader can never
   // be active in the same state, so a simple mux is enough. No write is
   // taken while reset is held.
   assign cpu_we  = (state == S_IDLE) && mem_write && !reset;
   assign prog_we = (state == S_PROG) && prog_valid && !reset;
   assign wr_en   = cpu_we || prog_we;
   assign wr_addr = cpu_we ? Address : ptr;
   assign wr_data = cpu_we ? Data : prog_data;

   // Array has no reset so its contents survive a reset.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         addr_q    <= '0;
         ptr       <= '0;
         rd_buf    <= '0;
         mem_ready <= 1'b0;
         prog_busy <= 1'b0;
         prog_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         prog_done <= 1'b0;
         // A read is acknowledged from the second DRIVE cycle on, which puts
         // the rising edge of mem_ready two clocks after mem_read is taken.
         // A write is acknowledged as soon as WACK is entered.
         mem_ready <= (state_nxt == S_WACK) ||
                      ((state == S_DRIVE) && (state_nxt == S_DRIVE));
         case (state)
            S_IDLE: begin
               if (!mem_write && mem_read) begin
                  addr_q <= Address;
               end else if (!mem_write && !mem_read && prog_start) begin
                  ptr       <= '0;
                  prog_busy <= 1'b1;
               end
            end
            S_RD: rd_buf <= mem[addr_q];
            S_PROG: begin
               if (prog_valid) begin
                  if (ptr == PTR_LAST) begin
                     ptr       <= '0;
                     prog_busy <= 1'b0;
                     prog_done <= 1'b1;
                  end else begin
                     ptr <= ptr + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Decoded straight from state so an async reset releases the bus at once.
   assign Data = (state == S_DRIVE) ? rd_buf : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram_responder.sv
module tb_ram_responder;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] address;
   wire  [7:0] data_bus;
   logic [7:0] tb_data;
   logic       tb_drive;
   logic       mem_read;
   logic       mem_write;
   logic       mem_ready;
   logic       prog_start;
   logic       prog_valid;
   logic [7:0] prog_data;
   logic       prog_busy;
   logic       prog_done;

   int         tests = 0;
   int         fails = 0;
   int         done_count = 0;
   bit         in_read = 1'b0;
   logic [7:0] model [256];
   logic [7:0] exp_q [$];
   vec_t       vecs [6];

   // Released bus reads back as all ones.
   pullup pu (data_bus);
   assign data_bus = tb_drive ? tb_data : 8'hzz;

   always #5 clk = ~clk;

   ram_responder #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .Address    (address),
      .Data       (data_bus),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_ready  (mem_ready),
      .prog_start (prog_start),
      .prog_valid (prog_valid),
      .prog_data  (prog_data),
      .prog_busy  (prog_busy),
      .prog_done  (prog_done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      tests++;
      if (act !== exp_v) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
      end
   endtask

   always @(negedge clk) if (prog_done) done_count++;

   // Outside a read transaction the DUT must never drive the bus.
   always @(posedge clk) begin
      #2;
      if (!reset && !tb_drive && !in_read)
         check("bus_not_driven", data_bus, 8'hFF);
   end

   task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      address = a; tb_data = d; tb_drive = 1'b1; mem_write = 1'b1;
      @(posedge clk); @(negedge clk);
      check("wr_ack", mem_ready, 1);
      model[a] = d;
      mem_write = 1'b0; tb_drive = 1'b0;
      @(posedge clk); @(negedge clk);
      check("wr_ack_drop", mem_ready, 0);
   endtask

   task automatic cpu_read(input logic [7:0] a);
      int edges;
      bit got;
      logic [7:0] exp_v;
      @(negedge clk);
      in_read = 1'b1; address = a; mem_read = 1'b1;
      exp_q.push_back(model[a]);
      @(posedge clk);
      edges = 0; got = 1'b0;
      while (!got && edges < 8) begin
         @(posedge clk); edges++;
         @(negedge clk);
         if (mem_ready) got = 1'b1;
      end
      check("rd_latency", edges, 2);
      exp_v = exp_q.pop_front();
      check("rd_data", data_bus, exp_v);
      mem_read = 1'b0;
      @(posedge clk); @(negedge clk);
      check("rd_bus_release", data_bus, 8'hFF);
      check("rd_ready_drop", mem_ready, 0);
      in_read = 1'b0;
   endtask

   task automatic prog_pulse();
      @(negedge clk);
      prog_start = 1'b1;
      @(posedge clk); @(negedge clk);
      prog_start = 1'b0;
      check("prog_busy_set", prog_busy, 1);
   endtask

   initial begin
      int i;
      int done_before;
      bit v;
      reset = 1'b1; address = '0; tb_data = '0; tb_drive = 1'b0;
      mem_read = 1'b0; mem_write = 1'b0; prog_start = 1'b0;
      prog_valid = 1'b0; prog_data = '0;

      repeat (2) @(negedge clk);
      check("rst_mem_ready", mem_ready, 0);
      check("rst_prog_busy", prog_busy, 0);
      check("rst_prog_done", prog_done, 0);
      check("rst_bus", data_bus, 8'hFF);
      reset = 1'b0;

      // Table-driven write then read-back.
      vecs = '{'{8'h10, 8'h5A}, '{8'h00, 8'h01}, '{8'hFF, 8'h80},
               '{8'h7F, 8'hC3}, '{8'h80, 8'h3C}, '{8'h11, 8'hA5}};
      for (int k = 0; k < 6; k++) cpu_write(vecs[k].addr, vecs[k].data);
      for (int k = 0; k < 6; k++) cpu_read(vecs[k].addr);
      cpu_write(8'h10, 8'h96);
      cpu_read(8'h10);

      // Held write with a changing bus: only the first value lands.
      @(negedge clk);
      address = 8'h30; tb_data = 8'h11; tb_drive = 1'b1; mem_write = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); @(negedge clk);
         check("held_wr_ready", mem_ready, 1);
         tb_data = tb_data + 8'h11;
      end
      mem_write = 1'b0; tb_drive = 1'b0;
      model[8'h30] = 8'h11;
      @(posedge clk); @(negedge clk);
      check("held_wr_drop", mem_ready, 0);
      cpu_read(8'h30);

      // Simultaneous read and write: write wins, bus stays released.
      @(negedge clk);
      address = 8'h20; tb_data = 8'h33; tb_drive = 1'b1;
      mem_write = 1'b1; mem_read = 1'b1;
      @(posedge clk); @(negedge clk);
      check("both_ready", mem_ready, 1);
      tb_drive = 1'b0;
      @(posedge clk); @(negedge clk);
      check("both_bus", data_bus, 8'hFF);
      check("both_wack", mem_ready, 1);
      mem_write = 1'b0; mem_read = 1'b0;
      model[8'h20] = 8'h33;
      @(posedge clk); @(negedge clk);
      check("both_drop", mem_ready, 0);
      cpu_read(8'h20);

      // Reset while driving releases the bus immediately.
      @(negedge clk);
      in_read = 1'b1; address = 8'h10; mem_read = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("drive_before_rst", data_bus, 8'h96);
      reset = 1'b1;
      #1;
      check("drive_rst_bus", data_bus, 8'hFF);
      check("drive_rst_ready", mem_ready, 0);
      @(negedge clk);
      reset = 1'b0; mem_read = 1'b0; in_read = 1'b0;

      // Full program load with random gaps and CPU reads ignored.
      done_before = done_count;
      prog_pulse();
      i = 0;
      while (i < 256) begin
         v = ($urandom_range(0, 3) != 0);
         prog_valid = v;
         prog_data = 8'(i) ^ 8'hFF;
         mem_read = (i < 20);
         @(posedge clk); @(negedge clk);
         if (v) begin
            model[i] = 8'(i) ^ 8'hFF;
            i++;
         end
         check("prog_no_ready", mem_ready, 0);
         if (i == 256) begin
            check("prog_done_last", prog_done, 1);
            check("prog_busy_clear", prog_busy, 0);
         end else begin
            check("prog_done_early", prog_done, 0);
            check("prog_busy_held", prog_busy, 1);
         end
      end
      prog_valid = 1'b0; mem_read = 1'b0;
      @(posedge clk); @(negedge clk);
      check("prog_done_pulse", prog_done, 0);
      @(posedge clk); @(negedge clk);
      check("prog_done_count", done_count - done_before, 1);
      cpu_read(8'h00);
      cpu_read(8'h01);
      cpu_read(8'h55);
      cpu_read(8'h7F);
      cpu_read(8'hFE);
      cpu_read(8'hFF);

      // Reset mid-load keeps written bytes and restarts the pointer.
      done_before = done_count;
      prog_pulse();
      for (int k = 0; k < 10; k++) begin
         prog_valid = 1'b1; prog_data = 8'hA0 + 8'(k);
         @(posedge clk); @(negedge clk);
         model[k] = 8'hA0 + 8'(k);
      end
      prog_valid = 1'b0;
      reset = 1'b1;
      #1;
      check("abort_busy", prog_busy, 0);
      check("abort_done", prog_done, 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); @(negedge clk);
      check("abort_no_done", done_count - done_before, 0);
      cpu_read(8'h00);
      cpu_read(8'h09);
      cpu_read(8'h0A);
      prog_pulse();
      prog_valid = 1'b1; prog_data = 8'hC3;
      @(posedge clk); @(negedge clk);
      model[0] = 8'hC3;
      prog_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      cpu_read(8'h00);
      cpu_read(8'h01);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
